// File: rtl/rename_stage_pkg.sv
// Shared types and sizing for the rename stage and its map table.
// The free list uses the same LEN/LBITS so physical tags line up.
package rename_stage_pkg;

  localparam int ARCH_REGS = 32;
  localparam int LEN       = 48;
  localparam int LBITS     = $clog2(LEN);
  localparam int MAX_WIDTH = 4;

  typedef logic [LBITS-1:0] ptag_t;

  typedef struct packed {
    logic ps1_v;
    logic ps2_v;
    logic old_v;
  } slot_flags_t;

  typedef struct packed {
    ptag_t       prd;
    ptag_t       old_prd;
    ptag_t       ps1;
    ptag_t       ps2;
    slot_flags_t flags;
  } renamed_slot_t;

  typedef struct packed {
    logic [2:0]                     count;
    renamed_slot_t [MAX_WIDTH-1:0]  slots;
  } renamed_bundle_t;

endpackage

// File: rtl/rename_map_table.sv
// Register alias table: per architectural register a mapped bit and a physical tag.
// 8 source read ports, 4 destination-lookup ports for displaced mappings, 4 slot-ordered writes.
module rename_map_table #(
  parameter int ARCH_REGS = rename_stage_pkg::ARCH_REGS,
  parameter int LBITS     = rename_stage_pkg::LBITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0][4:0]       src_addr,
  output logic [7:0]            src_v,
  output logic [7:0][LBITS-1:0] src_tag,
  input  logic [3:0][4:0]       dst_addr,
  output logic [3:0]            dst_v,
  output logic [3:0][LBITS-1:0] dst_tag,
  input  logic [3:0]            we,
  input  logic [3:0][4:0]       waddr,
  input  logic [3:0][LBITS-1:0] wdata
);

  logic [ARCH_REGS-1:0] mapped;
  logic [LBITS-1:0]     tags [ARCH_REGS];

  // Later write ports override earlier ones, so the highest slot wins on duplicate rd.
  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mapped <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (we[k] && waddr[k] != '0) mapped[waddr[k]] <= 1'b1;
      end
    end
  end

  // NOTE: tag storage is not reset; every read is masked by the mapped bit, which is.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) tags[waddr[k]] <= wdata[k];
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      src_v[i]   = mapped[src_addr[i]];
      src_tag[i] = src_v[i] ? tags[src_addr[i]] : '0;
    end
    for (int i = 0; i < 4; i++) begin
      dst_v[i]   = mapped[dst_addr[i]];
      dst_tag[i] = dst_v[i] ? tags[dst_addr[i]] : '0;
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: requests free registers on accept, assigns grants and updates the RAT
// one cycle later (stage A), then queues renamed bundles in a 2-entry output FIFO.
module rename_stage #(
  parameter int ARCH_REGS = rename_stage_pkg::ARCH_REGS,
  parameter int LEN       = rename_stage_pkg::LEN,
  parameter int LBITS     = $clog2(LEN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_count,
  input  logic [4:0]       i_rd0, i_rd1, i_rd2, i_rd3,
  input  logic [4:0]       i_rs1_0, i_rs1_1, i_rs1_2, i_rs1_3,
  input  logic [4:0]       i_rs2_0, i_rs2_1, i_rs2_2, i_rs2_3,
  output logic [2:0]       o_fl_req_count,
  input  logic [LBITS-1:0] i_fl_req0, i_fl_req1, i_fl_req2, i_fl_req3,
  input  logic [LBITS-1:0] i_fl_avail_count,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2:0]       o_count,
  output logic [LBITS-1:0] o_prd0, o_prd1, o_prd2, o_prd3,
  output logic [LBITS-1:0] o_old_prd0, o_old_prd1, o_old_prd2, o_old_prd3,
  output logic [LBITS-1:0] o_ps1_0, o_ps1_1, o_ps1_2, o_ps1_3,
  output logic [LBITS-1:0] o_ps2_0, o_ps2_1, o_ps2_2, o_ps2_3,
  output logic [3:0]       o_ps1_v,
  output logic [3:0]       o_ps2_v,
  output logic [3:0]       o_old_v
);
  import rename_stage_pkg::*;

  logic [3:0][4:0]       in_rd, in_rs1, in_rs2;
  logic [3:0][LBITS-1:0] grant;
  logic [3:0]            in_wr;
  logic [2:0]            need;
  logic                  accept;

  assign in_rd  = {i_rd3, i_rd2, i_rd1, i_rd0};
  assign in_rs1 = {i_rs1_3, i_rs1_2, i_rs1_1, i_rs1_0};
  assign in_rs2 = {i_rs2_3, i_rs2_2, i_rs2_1, i_rs2_0};
  assign grant  = {i_fl_req3, i_fl_req2, i_fl_req1, i_fl_req0};

  always_comb begin
    need = '0;
    for (int k = 0; k < 4; k++) begin
      in_wr[k] = (3'(k) < i_count) && (in_rd[k] != '0);
      need     = need + {2'b00, in_wr[k]};
    end
  end

  // Occupancy counts stage A plus FIFO, net of this cycle's dispatch, so the
  // grant-consuming cycle always finds FIFO space.
  logic [1:0] fifo_count;
  logic       a_valid;
  logic       pop;
  logic [2:0] occ;

  assign o_valid        = (fifo_count != '0);
  assign pop            = o_valid && i_ready;
  assign occ            = {1'b0, fifo_count} + {2'b00, a_valid} - {2'b00, pop};
  assign o_ready        = i_rst_n && (occ < 3'd2) && (LBITS'(need) <= i_fl_avail_count);
  assign accept         = i_valid && o_ready;
  assign o_fl_req_count = accept ? need : '0;

  logic [2:0]      a_count;
  logic [3:0][4:0] a_rd, a_rs1, a_rs2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_valid <= 1'b0;
      a_count <= '0;
      a_rd    <= '0;
      a_rs1   <= '0;
      a_rs2   <= '0;
    end else begin
      a_valid <= accept;
      if (accept) begin
        a_count <= i_count;
        a_rd    <= in_rd;
        a_rs1   <= in_rs1;
        a_rs2   <= in_rs2;
      end
    end
  end

  logic [7:0]            src_v;
  logic [7:0][LBITS-1:0] src_tag;
  logic [3:0]            dst_v;
  logic [3:0][LBITS-1:0] dst_tag;
  logic [3:0]            a_wr;
  logic [3:0][LBITS-1:0] wdata;
  renamed_bundle_t       a_out;

  rename_map_table #(.ARCH_REGS(ARCH_REGS), .LBITS(LBITS)) u_map (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .src_addr ({a_rs2, a_rs1}),
    .src_v    (src_v),
    .src_tag  (src_tag),
    .dst_addr (a_rd),
    .dst_v    (dst_v),
    .dst_tag  (dst_tag),
    .we       (a_wr),
    .waddr    (a_rd),
    .wdata    (wdata)
  );

  // Slots are walked in order: grants are handed out to writers in turn and
  // earlier same-bundle writes bypass the RAT for later sources and old mappings.
  always_comb begin
    logic [1:0] gidx;
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    a_out       = '0;
    a_out.count = a_count;
    a_wr        = '0;
    gidx        = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < a_count) begin
        a_wr[k]                   = a_valid && (a_rd[k] != '0);
        a_out.slots[k].flags.ps1_v = src_v[k];
        a_out.slots[k].ps1         = src_tag[k];
        a_out.slots[k].flags.ps2_v = src_v[4+k];
        a_out.slots[k].ps2         = src_tag[4+k];
        for (int i = 0; i < k; i++) begin
          if (a_wr[i] && a_rd[i] == a_rs1[k]) begin
            a_out.slots[k].flags.ps1_v = 1'b1;
            a_out.slots[k].ps1         = a_out.slots[i].prd;
          end
          if (a_wr[i] && a_rd[i] == a_rs2[k]) begin
            a_out.slots[k].flags.ps2_v = 1'b1;
            a_out.slots[k].ps2         = a_out.slots[i].prd;
          end
        end
        if (a_wr[k]) begin
          a_out.slots[k].flags.old_v = dst_v[k];
          a_out.slots[k].old_prd     = dst_tag[k];
          for (int i = 0; i < k; i++) begin
            if (a_wr[i] && a_rd[i] == a_rd[k]) begin
              a_out.slots[k].flags.old_v = 1'b1;
              a_out.slots[k].old_prd     = a_out.slots[i].prd;
            end
          end
          a_out.slots[k].prd = grant[gidx];
          gidx               = gidx + 2'd1;
        end
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_wdata
    assign wdata[k] = a_out.slots[k].prd;
  end

  renamed_bundle_t fifo_mem [2];
  renamed_bundle_t head;
  logic            wr_ptr, rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (a_valid) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, a_valid} - {1'b0, pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (a_valid) fifo_mem[wr_ptr] <= a_out;
  end

  assign head    = o_valid ? fifo_mem[rd_ptr] : '0;
  assign o_count = head.count;

  assign o_prd0     = head.slots[0].prd;
  assign o_prd1     = head.slots[1].prd;
  assign o_prd2     = head.slots[2].prd;
  assign o_prd3     = head.slots[3].prd;
  assign o_old_prd0 = head.slots[0].old_prd;
  assign o_old_prd1 = head.slots[1].old_prd;
  assign o_old_prd2 = head.slots[2].old_prd;
  assign o_old_prd3 = head.slots[3].old_prd;
  assign o_ps1_0    = head.slots[0].ps1;
  assign o_ps1_1    = head.slots[1].ps1;
  assign o_ps1_2    = head.slots[2].ps1;
  assign o_ps1_3    = head.slots[3].ps1;
  assign o_ps2_0    = head.slots[0].ps2;
  assign o_ps2_1    = head.slots[1].ps2;
  assign o_ps2_2    = head.slots[2].ps2;
  assign o_ps2_3    = head.slots[3].ps2;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      o_ps1_v[k] = head.slots[k].flags.ps1_v;
      o_ps2_v[k] = head.slots[k].flags.ps2_v;
      o_old_v[k] = head.slots[k].flags.old_v;
    end
  end

endmodule

// File: doc/rename_stage.md
# rename_stage

- Allocating end of the physical-register free list: accepts decoded bundles of up to four instructions and requests one physical register per real destination.
- Captures the granted registers one cycle later and updates the register alias table (RAT).
- Emits renamed bundles to dispatch, with source mappings and each displaced (old) destination mapping for the ROB, which later returns them to the free list.

## Interface
Parameters:
- `ARCH_REGS`, 32, architectural registers; x0 is never renamed.
- `LEN`, 48, physical registers; must match the free list.
- `LBITS`, `$clog2(LEN)`, physical tag width.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_valid`  in  1  decode bundle valid.
- `o_ready`  out  1  bundle accepted when `i_valid && o_ready`.
- `i_count`  in  3  bundle slots, 1..4; slot k is live iff k < `i_count`.
- `i_rd0..3`, `i_rs1_0..3`, `i_rs2_0..3`  in  5 each  architectural registers per slot.
- `o_fl_req_count`  out  3  to free list `i_req_count`.
- `i_fl_req0..3`  in  `LBITS` each  free list grants, valid the cycle after the request.
- `i_fl_avail_count`  in  `LBITS`  free list available count.
- `o_valid`  out  1  renamed bundle valid.
- `i_ready`  in  1  dispatch accepts when `o_valid && i_ready`.
- `o_count`  out  3  slot count of the output bundle.
- `o_prd0..3`, `o_old_prd0..3`  out  `LBITS` each  new and displaced destination tags.
- `o_ps1_0..3`, `o_ps2_0..3`  out  `LBITS` each  source tags.
- `o_ps1_v`, `o_ps2_v`, `o_old_v`  out  4 each  tag-mapped flags; 0 means the operand is architectural zero / unmapped.

## Operation
- Slot k "writes" iff live and `i_rdk != 0`.
- need = number of writing slots (0..4).
- `o_fl_req_count` = need when a bundle is accepted, else 0; never nonzero otherwise.
- Accept condition: `o_ready` = (occ < 2) && (need ≤ `i_fl_avail_count`).
  - occ = out_fifo_count + a_valid − (`o_valid && i_ready`).
  - `i_ready` → `o_ready` is a combinational path, by design.
- Stage A latches the accepted bundle and need.
- In the following cycle, grants are assigned in slot order: the j-th writing slot gets `i_fl_req`j.
- Sources of slot k see writes of slots < k in the same bundle (bypass); otherwise they read the RAT.
- `o_old_prdk` is the mapping of rd just before slot k, including earlier same-bundle writes.
- The RAT is written at the end of that cycle; on duplicate rd within a bundle, the highest slot wins.
- The result enters a 2-entry output FIFO.
- Non-writing slots: `o_prdk` = 0, `o_old_v[k]` = 0.
- RAT entries carry a mapped bit, cleared at reset (matches free list reset all-free).
- Unmapped or x0 sources give tag 0 with valid 0.
- need = 0 bundles still flow through with no free-list request.

## Timing
- Accept at cycle t → request at t → grants sampled at t+1 → RAT updated at edge end of t+1 → `o_valid` at t+2 at the earliest.
- Sustained throughput: one bundle per cycle while `i_ready`=1 and registers are available.
- Grants are consumed exactly in cycle t+1, never later; the occupancy rule guarantees FIFO space.
- `i_fl_avail_count` is compared before the free list's own update.
- Reset values: `o_ready`=0 during reset; `o_valid`=0; `o_fl_req_count`=0; all tags=0; all v flags=0; FIFO empty; stage A empty; all RAT mapped bits=0.
- Reset mid-operation discards stage A and FIFO contents.
- No request is issued on the first cycle after reset deassertion unless a bundle is accepted.

## Structure
- Shared package: `ARCH_REGS`, `LEN`, `LBITS`, `MAX_WIDTH`=4, and a renamed-slot struct {prd, old_prd, ps1, ps2, flags}. The free list uses the same `LEN`/`LBITS`.
- Sub-module `rename_map_table`:
  - `ARCH_REGS` × (mapped bit + `LBITS`) storage.
  - 8 asynchronous read ports, 4 slot-ordered write ports.
  - Asynchronous active-low clear of mapped bits.
- Top level holds stage A, the grant-assignment/bypass logic and the output FIFO.

## Test plan
- After reset, bundle {count=1, rd=5, rs1=5}: `o_fl_req_count`=1; grant tag 0 → at t+2 `o_prd0`=0, `o_ps1_v[0]`=0, `o_old_v[0]`=0.
- Bundle rd={3,3,4,0}, rs1_1=3, grants {10,11,12}:
  - `o_prd`={10,11,12,0}.
  - `o_ps1_1`=10 valid.
  - `o_old_prd1`=10.
  - RAT[3]=11 afterwards.
- `i_fl_avail_count`=2, bundle need=3: `o_ready`=0, `o_fl_req_count`=0; raising avail to 3 → accepted.
- `i_ready` held 0 for 4 cycles with `i_valid`=1:
  - exactly 2 bundles accepted, then `o_ready`=0;
  - releasing `i_ready` drains in order with no lost grants.
- Back-to-back need=4 bundles with `i_ready`=1: one accept per cycle, `o_valid` continuous from t+2.
- Assert `i_rst_n`=0 with a bundle in stage A: outputs return to reset values immediately; subsequent source reads of that rd show valid=0.
